calc_arbiter: RTL and testbench



---
 rtl/calc_pkg.sv | 29 ++
 rtl/calc_arbiter_if.sv | 63 ++++++
 rtl/calc_rr_grant.sv | 21 ++
 rtl/calc_arbiter.sv | 106 ++++++++++
 tb/tb_calc_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared widths, opcodes, FSM states and requester ID type for the
// two-requester calculator arbiter.
package calc_pkg;

    localparam int OPW  = 4;
    localparam int OUTW = 2 * OPW;

    localparam logic [2:0] OP_000     = 3'b000;
    localparam logic [2:0] OP_001     = 3'b001;
    localparam logic [2:0] OP_010     = 3'b010;
    localparam logic [2:0] OP_011     = 3'b011;
    localparam logic [2:0] OP_100     = 3'b100;
    localparam logic [2:0] OP_101     = 3'b101;
    localparam logic [2:0] OP_111     = 3'b111;
    localparam logic [2:0] ILLEGAL_OP = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic req_id_t;

    function automatic logic is_illegal(input logic [2:0] op);
        return op == ILLEGAL_OP;
    endfunction

endpackage

// File: rtl/calc_arbiter_if.sv
// Request, response and calculator-side signals of the arbiter. The slave
// modport is the arbiter's view; master is the clients plus calculator.
interface calc_arbiter_if;
    import calc_pkg::*;

    logic            req0_valid;
    logic            req0_ready;
    logic [OPW-1:0]  req0_a;
    logic [OPW-1:0]  req0_b;
    logic [2:0]      req0_oper;

    logic            req1_valid;
    logic            req1_ready;
    logic [OPW-1:0]  req1_a;
    logic [OPW-1:0]  req1_b;
    logic [2:0]      req1_oper;

    logic            resp0_valid;
    logic            resp0_ready;
    logic [OUTW-1:0] resp0_out;
    logic            resp0_err;

    logic            resp1_valid;
    logic            resp1_ready;
    logic [OUTW-1:0] resp1_out;
    logic            resp1_err;

    logic [OPW-1:0]  calc_a;
    logic [OPW-1:0]  calc_b;
    logic [2:0]      calc_oper;
    logic [OUTW-1:0] calc_out;

    logic            busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_oper,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_oper,
        output req1_ready,
        output resp0_valid, resp0_out, resp0_err,
        input  resp0_ready,
        output resp1_valid, resp1_out, resp1_err,
        input  resp1_ready,
        output calc_a, calc_b, calc_oper,
        input  calc_out,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_oper,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_oper,
        input  req1_ready,
        input  resp0_valid, resp0_out, resp0_err,
        output resp0_ready,
        input  resp1_valid, resp1_out, resp1_err,
        output resp1_ready,
        input  calc_a, calc_b, calc_oper,
        output calc_out,
        input  busy
    );

endinterface

// File: rtl/calc_rr_grant.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to
// the requester named by the priority pointer.
module calc_rr_grant
    import calc_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/calc_arbiter.sv
// Round-robin sharing of one external combinational calculator between two
// valid/ready requesters, with one registered response per operation.
module calc_arbiter
    import calc_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    calc_arbiter_if.slave bus
);

    state_t          state_reg;
    req_id_t         ptr_reg;
    req_id_t         owner_reg;
    logic [OPW-1:0]  calc_a_reg;
    logic [OPW-1:0]  calc_b_reg;
    logic [2:0]      calc_oper_reg;
    logic [1:0]      resp_valid_reg;
    logic [1:0]      resp_err_reg;
    logic [OUTW-1:0] resp_out_reg [2];

    logic [1:0]      req_valid;
    logic [1:0]      resp_ready;
    logic [1:0]      grant;
    logic [1:0]      ready_int;
    logic [OPW-1:0]  a_in;
    logic [OPW-1:0]  b_in;
    logic [2:0]      oper_in;

    assign req_valid  = {bus.req1_valid,  bus.req0_valid};
    assign resp_ready = {bus.resp1_ready, bus.resp0_ready};

    calc_rr_grant u_grant (
        .valid (req_valid),
        .ptr   (ptr_reg),
        .grant (grant)
    );

    // Gated with rst so a request can never complete a handshake while the
    // block is being reset.
    assign ready_int = (state_reg == IDLE && !rst) ? grant : 2'b00;

    assign a_in    = grant[1] ? bus.req1_a    : bus.req0_a;
    assign b_in    = grant[1] ? bus.req1_b    : bus.req0_b;
    assign oper_in = grant[1] ? bus.req1_oper : bus.req0_oper;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            ptr_reg         <= 1'b0;
            owner_reg       <= 1'b0;
            calc_a_reg      <= '0;
            calc_b_reg      <= '0;
            calc_oper_reg   <= '0;
            resp_valid_reg  <= 2'b00;
            resp_err_reg    <= 2'b00;
            resp_out_reg[0] <= '0;
            resp_out_reg[1] <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|ready_int) begin
                        owner_reg     <= grant[1];
                        calc_a_reg    <= a_in;
                        calc_b_reg    <= b_in;
                        calc_oper_reg <= oper_in;
                        state_reg     <= CALC;
                    end
                end
                CALC: begin
                    // The illegal opcode never trusts whatever the calculator returns.
                    if (is_illegal(calc_oper_reg)) begin
                        resp_out_reg[owner_reg] <= '0;
                        resp_err_reg[owner_reg] <= 1'b1;
                    end else begin
                        resp_out_reg[owner_reg] <= bus.calc_out;
                        resp_err_reg[owner_reg] <= 1'b0;
                    end
                    resp_valid_reg[owner_reg] <= 1'b1;
                    state_reg                 <= RESP;
                end
                RESP: begin
                    if (resp_ready[owner_reg]) begin
                        resp_valid_reg[owner_reg] <= 1'b0;
                        ptr_reg                   <= ~owner_reg;
                        state_reg                 <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready  = ready_int[0];
    assign bus.req1_ready  = ready_int[1];
    assign bus.resp0_valid = resp_valid_reg[0];
    assign bus.resp1_valid = resp_valid_reg[1];
    assign bus.resp0_out   = resp_out_reg[0];
    assign bus.resp1_out   = resp_out_reg[1];
    assign bus.resp0_err   = resp_err_reg[0];
    assign bus.resp1_err   = resp_err_reg[1];
    assign bus.calc_a      = calc_a_reg;
    assign bus.calc_b      = calc_b_reg;
    assign bus.calc_oper   = calc_oper_reg;
    assign bus.busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_calc_arbiter.sv
// Scoreboard bench: accepted requests push their expected response, a
// negedge monitor pops and compares on every response handshake.
module tb_calc_arbiter;
    import calc_pkg::*;

    typedef struct {
        int         id;
        logic [7:0] out;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   resp_count = 0;
    exp_t sb [$];

    calc_arbiter_if bus ();

    calc_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Calculator stub: result is simply the operand concatenation.
    assign bus.calc_out = {bus.calc_a, bus.calc_b};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.resp0_valid || bus.resp1_valid)
                check("resp_exclusive", {31'd0, bus.resp0_valid & bus.resp1_valid}, 32'd0);
            for (int i = 0; i < 2; i++) begin
                logic       v, r, e;
                logic [7:0] o;
                v = i ? bus.resp1_valid : bus.resp0_valid;
                r = i ? bus.resp1_ready : bus.resp0_ready;
                o = i ? bus.resp1_out   : bus.resp0_out;
                e = i ? bus.resp1_err   : bus.resp0_err;
                if (v && r) begin
                    resp_count++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: requester %0d out=%0h with empty scoreboard", i, o);
                    end else begin
                        exp_t x;
                        x = sb.pop_front();
                        check("resp_id", i, x.id);
                        check("resp_out", {24'd0, o}, {24'd0, x.out});
                        check("resp_err", {31'd0, e}, {31'd0, x.err});
                        $display("resp req%0d out=%02h err=%0d (exp req%0d %02h %0d)", i, o, e, x.id, x.out, x.err);
                    end
                end
            end
        end
    end

    task automatic set_req(input int id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        if (id == 0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_oper = op; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_oper = op; bus.req1_valid = 1'b1;
        end
    endtask

    // Returns just after the accepting edge (#1), i.e. inside CALC.
    task automatic wait_accept(input int id, input bit push);
        bit   ok = 0;
        exp_t x;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if ((id == 0 && bus.req0_ready) || (id == 1 && bus.req1_ready)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: requester %0d never got ready", id);
        end else if (push) begin
            logic [3:0] a, b;
            logic [2:0] op;
            a  = id ? bus.req1_a    : bus.req0_a;
            b  = id ? bus.req1_b    : bus.req0_b;
            op = id ? bus.req1_oper : bus.req0_oper;
            x.id  = id;
            x.err = (op == 3'b110);
            x.out = x.err ? 8'h00 : {a, b};
            sb.push_back(x);
            $display("issue req%0d a=%b b=%b op=%b", id, a, b, op);
        end
        @(posedge clk);
        #1;
        if (id == 0) bus.req0_valid = 1'b0;
        else         bus.req1_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready0"}, {31'd0, bus.req0_ready}, 32'd0);
        check({tag, "_ready1"}, {31'd0, bus.req1_ready}, 32'd0);
        check({tag, "_rvalid"}, {30'd0, bus.resp1_valid, bus.resp0_valid}, 32'd0);
        check({tag, "_rout"},   {16'd0, bus.resp1_out, bus.resp0_out}, 32'd0);
        check({tag, "_rerr"},   {30'd0, bus.resp1_err, bus.resp0_err}, 32'd0);
        check({tag, "_calc"},   {21'd0, bus.calc_a, bus.calc_b, bus.calc_oper}, 32'd0);
        check({tag, "_busy"},   {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && sb.size() != 0; n++) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        logic [2:0] ops [7];
        ops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b111};
        bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_oper = 0;
        bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_oper = 0;
        bus.resp0_ready = 1; bus.resp1_ready = 1;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 0;

        // Single request with latency checks
        set_req(0, 4'b1001, 4'b0011, 3'b000);
        wait_accept(0, 1);
        @(negedge clk);
        check("calc_a", {28'd0, bus.calc_a}, 32'b1001);
        check("calc_b", {28'd0, bus.calc_b}, 32'b0011);
        check("calc_busy", {31'd0, bus.busy}, 32'd1);
        check("calc_no_valid", {31'd0, bus.resp0_valid}, 32'd0);
        @(negedge clk);
        check("resp0_valid_t2", {31'd0, bus.resp0_valid}, 32'd1);
        drain();

        // Contention and alternation; pointer is 1 after the single request
        set_req(0, 4'b0011, 4'b0100, 3'b010);
        set_req(1, 4'b0101, 4'b0001, 3'b001);
        wait_accept(1, 1);
        wait_accept(0, 1);
        set_req(0, 4'b1111, 4'b0000, 3'b011);
        set_req(1, 4'b1010, 4'b0101, 3'b100);
        wait_accept(1, 1);
        wait_accept(0, 1);
        drain();

        // Response backpressure with a competing request held
        bus.resp0_ready = 0;
        set_req(0, 4'b0110, 4'b1100, 3'b101);
        wait_accept(0, 1);
        set_req(1, 4'b0001, 4'b0010, 3'b000);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, bus.resp0_valid}, 32'd1);
            check("bp_out", {24'd0, bus.resp0_out}, 32'h6C);
            check("bp_busy", {31'd0, bus.busy}, 32'd1);
            check("bp_ready1", {31'd0, bus.req1_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.resp0_ready = 1;
        wait_accept(1, 1);
        drain();

        // Illegal opcode then a legal one
        set_req(1, 4'b1001, 4'b0011, 3'b110);
        wait_accept(1, 1);
        drain();
        set_req(1, 4'b0111, 4'b1000, 3'b010);
        wait_accept(1, 1);
        drain();

        // Reset in CALC, pointer left at 1 beforehand (last owner was req0 below)
        set_req(0, 4'b0001, 4'b0001, 3'b000);
        wait_accept(0, 1);
        drain();
        set_req(0, 4'b1110, 4'b1110, 3'b001);
        wait_accept(0, 0);
        rst = 1;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_calc");
        rst = 0;
        // Reset in RESP
        bus.resp0_ready = 0;
        set_req(0, 4'b1101, 4'b1011, 3'b001);
        wait_accept(0, 0);
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_resp");
        rst = 0;
        bus.resp0_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check("no_stale_resp", {30'd0, bus.resp1_valid, bus.resp0_valid}, 32'd0);
        // Pointer must be 0 again: tie goes to req0
        set_req(0, 4'b0010, 4'b0010, 3'b011);
        set_req(1, 4'b0100, 4'b0100, 3'b011);
        wait_accept(0, 1);
        wait_accept(1, 1);
        drain();

        // Opcode sweep from alternating requesters
        base = resp_count;
        for (int k = 0; k < 7; k++) begin
            set_req(k % 2, 4'b1001, 4'b0011, ops[k]);
            wait_accept(k % 2, 1);
        end
        drain();
        check("sweep_count", resp_count - base, 32'd7);
        check("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
